// File: rtl/bram_tdp_responder.sv
// bram_tdp_responder: single-clock true dual-port memory responder.
// Two independent read/write ports (A, B) share one storage array.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   rce_x, ra_x, rq_x    : port x read enable, read address, read data
//   wce_x, wa_x, wd_x    : port x write enable, write address, write data
//   coll                 : one-cycle pulse after both ports wrote one address
// READ_MODE 0 = read-first, 1 = write-first (same-address reads only).
// OUT_REG   0 = read latency 1, 1 = extra output register (latency 2).
module bram_tdp_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned READ_MODE  = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rce_a,
    input  logic [ADDR_WIDTH-1:0] ra_a,
    output logic [DATA_WIDTH-1:0] rq_a,
    input  logic                  wce_a,
    input  logic [ADDR_WIDTH-1:0] wa_a,
    input  logic [DATA_WIDTH-1:0] wd_a,
    input  logic                  rce_b,
    input  logic [ADDR_WIDTH-1:0] ra_b,
    output logic [DATA_WIDTH-1:0] rq_b,
    input  logic                  wce_b,
    input  logic [ADDR_WIDTH-1:0] wa_b,
    input  logic [DATA_WIDTH-1:0] wd_b,
    output logic                  coll
);

    localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
    localparam bit          WRITE_FIRST = (READ_MODE != 0);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_a;
    logic [DATA_WIDTH-1:0] r_rd_b;
    logic                  r_coll;

    logic                  w_same_wr;
    logic [DATA_WIDTH-1:0] w_rdata_a;
    logic [DATA_WIDTH-1:0] w_rdata_b;

    assign w_same_wr = wce_a && wce_b && (wa_a == wa_b);

    // Write-first forwarding: port A wins when both ports write the read address.
    assign w_rdata_a = (WRITE_FIRST && wce_a && (wa_a == ra_a)) ? wd_a :
                       (WRITE_FIRST && wce_b && (wa_b == ra_a)) ? wd_b :
                       r_mem[ra_a];
    assign w_rdata_b = (WRITE_FIRST && wce_a && (wa_a == ra_b)) ? wd_a :
                       (WRITE_FIRST && wce_b && (wa_b == ra_b)) ? wd_b :
                       r_mem[ra_b];

    // Storage is never reset; writes are dropped while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wce_b && !w_same_wr) begin
                r_mem[wa_b] <= wd_b;
            end
            if (wce_a) begin
                r_mem[wa_a] <= wd_a;
            end
        end
    end

    // Read registers and collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
            r_coll <= 1'b0;
        end else begin
            if (rce_a) begin
                r_rd_a <= w_rdata_a;
            end
            if (rce_b) begin
                r_rd_b <= w_rdata_b;
            end
            r_coll <= w_same_wr;
        end
    end

    assign coll = r_coll;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_vld_a;
        logic                  r_vld_b;
        logic [DATA_WIDTH-1:0] r_out_a;
        logic [DATA_WIDTH-1:0] r_out_b;

        // Output stage only advances on words that were actually read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld_a <= 1'b0;
                r_vld_b <= 1'b0;
                r_out_a <= '0;
                r_out_b <= '0;
            end else begin
                r_vld_a <= rce_a;
                r_vld_b <= rce_b;
                if (r_vld_a) begin
                    r_out_a <= r_rd_a;
                end
                if (r_vld_b) begin
                    r_out_b <= r_rd_b;
                end
            end
        end

        assign rq_a = r_out_a;
        assign rq_b = r_out_b;
    end else begin : g_no_out_reg
        assign rq_a = r_rd_a;
        assign rq_b = r_rd_b;
    end

endmodule

// File: tb/tb_bram_tdp_responder.sv
// Bench for bram_tdp_responder: two instances (read-first/latency 1 and
// write-first/latency 2) share one stimulus stream and one reference model.
module tb_bram_tdp_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rce [2];
    logic [AW-1:0] ra  [2];
    logic          wce [2];
    logic [AW-1:0] wa  [2];
    logic [DW-1:0] wd  [2];

    logic [DW-1:0] rq0_a, rq0_b, rq1_a, rq1_b;
    logic          coll0, coll1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bram_tdp_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE(0), .OUT_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rce_a(rce[0]), .ra_a(ra[0]), .rq_a(rq0_a), .wce_a(wce[0]), .wa_a(wa[0]), .wd_a(wd[0]),
        .rce_b(rce[1]), .ra_b(ra[1]), .rq_b(rq0_b), .wce_b(wce[1]), .wa_b(wa[1]), .wd_b(wd[1]),
        .coll(coll0)
    );

    bram_tdp_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rce_a(rce[0]), .ra_a(ra[0]), .rq_a(rq1_a), .wce_a(wce[0]), .wa_a(wa[0]), .wd_a(wd[0]),
        .rce_b(rce[1]), .ra_b(ra[1]), .rq_b(rq1_b), .wce_b(wce[1]), .wa_b(wa[1]), .wd_b(wd[1]),
        .coll(coll1)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: word-level memory plus per-port expected outputs.
    logic [DW-1:0] m_mem [1 << AW];
    logic [DW-1:0] e0 [2] = '{default: '0};   // read-first, latency 1
    logic [DW-1:0] e1 [2] = '{default: '0};   // write-first, latency 2
    logic [DW-1:0] pw [2] = '{default: '0};   // word read last edge, due next edge
    logic          pv [2] = '{default: 1'b0};
    logic          ecoll = 1'b0;

    // Value an address holds once this edge's writes land (port A wins).
    function automatic logic [DW-1:0] stored_after(input logic [AW-1:0] x);
        if (wce[0] && wa[0] == x) return wd[0];
        if (wce[1] && wa[1] == x) return wd[1];
        return m_mem[x];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                e0[p] = '0;
                e1[p] = '0;
                pw[p] = '0;
                pv[p] = 1'b0;
            end
            ecoll = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (pv[p]) e1[p] = pw[p];
                pv[p] = rce[p];
                if (rce[p]) begin
                    e0[p] = m_mem[ra[p]];
                    pw[p] = stored_after(ra[p]);
                end
            end
            ecoll = wce[0] && wce[1] && (wa[0] == wa[1]);
            if (wce[1]) m_mem[wa[1]] = wd[1];
            if (wce[0]) m_mem[wa[0]] = wd[0];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("c0_rq_a", rq0_a, e0[0]);
            check("c0_rq_b", rq0_b, e0[1]);
            check("c1_rq_a", rq1_a, e1[0]);
            check("c1_rq_b", rq1_b, e1[1]);
            check("c0_coll", DW'(coll0), DW'(ecoll));
            check("c1_coll", DW'(coll1), DW'(ecoll));
        end
    end

    function automatic logic [DW-1:0] pat(input int unsigned a);
        logic [DW-1:0] v;
        v = DW'(a);
        return v | (v << 20) | DW'(36'h55000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < 2; p++) begin
            rce[p] = 1'b0;
            wce[p] = 1'b0;
        end
    endtask

    task automatic wr(input int p, input int unsigned a, input logic [DW-1:0] d);
        wce[p] = 1'b1;
        wa[p]  = AW'(a);
        wd[p]  = d;
    endtask

    task automatic rd(input int p, input int unsigned a);
        rce[p] = 1'b1;
        ra[p]  = AW'(a);
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            ra[p] = '0;
            wa[p] = '0;
            wd[p] = '0;
        end
        idle();
        step();
        chk_en = 1'b1;
        step();
        check("rst_rq_a", rq0_a, '0);
        check("rst_rq_b", rq1_b, '0);

        // Write before reset, then reset with activity aimed at that word.
        rst_n = 1'b1;
        wr(0, 100, 36'h0DEADBEEF);
        step();
        idle();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rce[0] = 1'($urandom);
            rce[1] = 1'($urandom);
            ra[0]  = AW'($urandom);
            ra[1]  = AW'($urandom);
            wr(0, 100, DW'({$urandom, $urandom}));
            wr(1, 100, DW'({$urandom, $urandom}));
            step();
            check("rst_hold_rq", rq0_a | rq0_b | rq1_a | rq1_b, '0);
            check("rst_hold_coll", DW'(coll0 | coll1), '0);
        end
        idle();
        rst_n = 1'b1;
        rd(0, 100);
        step();
        check("post_rst_c0", rq0_a, 36'h0DEADBEEF);
        idle();
        step();
        check("post_rst_c1", rq1_a, 36'h0DEADBEEF);

        // Split-half fill and readback.
        for (int i = 0; i < 512; i++) begin
            wr(0, i, pat(i));
            wr(1, 512 + i, pat(512 + i));
            step();
        end
        idle();
        for (int i = 0; i < 512; i++) begin
            rd(0, i);
            rd(1, 512 + i);
            step();
            if (i == 5) check("fill_addr5", rq0_a, 36'h000555005);
        end
        idle();
        step();
        check("fill_last_a", rq1_a, 36'h01FF551FF);
        check("fill_last_b", rq1_b, 36'h03FF553FF);

        // Cross-port readback and hold.
        wr(0, 7, 36'h123456789);
        step();
        idle();
        rd(1, 7);
        step();
        check("xport_c0", rq0_b, 36'h123456789);
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            check("xport_hold_c0", rq0_b, 36'h123456789);
            check("xport_hold_c1", rq1_b, 36'h123456789);
        end

        // Read-during-write, cross port.
        wr(0, 3, 36'h0AAAAAAAA);
        step();
        idle();
        wr(0, 3, 36'h155555555);
        rd(1, 3);
        step();
        check("rdw_read_first", rq0_b, 36'h0AAAAAAAA);
        idle();
        step();
        check("rdw_write_first", rq1_b, 36'h155555555);

        // Write collision.
        wr(0, 9, 36'h111111111);
        wr(1, 9, 36'h222222222);
        step();
        idle();
        check("coll_c0", DW'(coll0), 36'h1);
        check("coll_c1", DW'(coll1), 36'h1);
        step();
        check("coll_drop", DW'(coll0 | coll1), '0);
        rd(0, 9);
        rd(1, 9);
        step();
        idle();
        check("coll_rd_a", rq0_a, 36'h111111111);
        check("coll_rd_b", rq0_b, 36'h111111111);
        step();
        check("coll_rd_c1", rq1_a, 36'h111111111);

        // Mixed traffic on a small window to provoke collisions and RDW.
        for (int k = 0; k < 300; k++) begin
            rce[0] = 1'($urandom);
            rce[1] = 1'($urandom);
            wce[0] = 1'($urandom);
            wce[1] = 1'($urandom);
            ra[0]  = AW'($urandom_range(31, 16));
            ra[1]  = AW'($urandom_range(31, 16));
            wa[0]  = AW'($urandom_range(31, 16));
            wa[1]  = AW'($urandom_range(31, 16));
            wd[0]  = DW'({$urandom, $urandom});
            wd[1]  = DW'({$urandom, $urandom});
            step();
        end
        idle();
        step();
        step();

        // Reset between the two latency edges of a latency-2 read.
        rd(0, 5);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        check("midrd_rst_c1", rq1_a, '0);
        check("midrd_rst_c0", rq0_a, '0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("midrd_stay0", rq1_a, '0);
        end
        rd(0, 5);
        step();
        idle();
        step();
        check("midrd_fresh", rq1_a, 36'h000555005);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
